obliczanie_taktowania_param: RTL and testbench
==============================================

Name: obliczanie_taktowania_param

Overview:
Parametrised successor to the fixed rpm-to-ticks-per-degree lookup in the stepper driver. Computes taktowanie_na_stopien = floor(K_TAKT / rpm) for any rpm, using a sequential restoring divider instead of a case table. Sits between the speed-setpoint logic and the step-pulse generator. Uses a start/valid handshake; out-of-range results saturate to all-ones.

Parameters:
RPM_W, 7, width of rpm input
OUT_W, 9, width of result
K_TAKT, 2000, tick-clock cycles per degree at 1 rpm (F_TICK*60/360; 2000 for 12 kHz tick)
Q_W, $clog2(K_TAKT+1), quotient/divider iteration count (derived, localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only when busy=0
rpm  input  RPM_W  speed in rpm, sampled on accepted start
busy  output  1  high from cycle after accepted start until the cycle valid is asserted
valid  output  1  one-cycle pulse: new result on taktowanie_na_stopien
taktowanie_na_stopien  output  OUT_W  ticks per degree, held between updates
nasycenie  output  1  result saturated (rpm=0 or quotient > 2^OUT_W-1); updated with valid

Behaviour:
- Reset, async, effective immediately: state IDLE, busy=0, valid=0, nasycenie=0, taktowanie_na_stopien=all-ones, divider registers cleared.
- FSM: IDLE -> DIV (start=1 in IDLE; latch rpm, load dividend K_TAKT, clear remainder and quotient, busy=1) -> DIV for exactly Q_W cycles (one quotient bit per cycle, MSB first; restoring: rem={rem,next dividend bit}; if rem>=rpm then rem-=rpm, q bit=1) -> DONE (1 cycle: register result, valid=1, busy=0) -> IDLE.
- Fixed latency: valid asserted Q_W+1 cycles after the clock edge that accepts start (12 for defaults). Latency does not depend on rpm.
- Remainder register width RPM_W+1; quotient width Q_W; no intermediate overflow.
- Saturation in DONE: if latched rpm==0 or quotient > 2^OUT_W-1, output all-ones and nasycenie=1; otherwise quotient truncated to OUT_W, nasycenie=0. rpm==0 still runs the full DIV sequence (compare always true, result forced).
- start while busy (DIV or DONE): ignored, no queuing; rpm changes during DIV have no effect.
- start in the same cycle valid pulses: the FSM is in DONE, so start is ignored; the earliest accept is the following cycle in IDLE.
- The output and nasycenie hold their values until the next DONE. valid is never high for 2 consecutive cycles.
- Reset mid-DIV: computation abandoned, no valid, output returns to all-ones.

Optional Feature:
ROUND_NEAREST_EN — when defined, DONE rounds to nearest: if 2*rem >= rpm, quotient+1 before the saturation check. Latency is unchanged, and the increment may trigger saturation. When undefined, the result is floor (truncation), matching the legacy table values.

Decomposition:
- Package obliczanie_pkg: state enum (IDLE, DIV, DONE), default K_TAKT, clog2 helper, saturation constant function for all-ones of OUT_W.
- One sub-module, dzielnik_sekwencyjny: generic restoring divider (params N_W, D_W; ports clk, rst, load, dividend, divisor, quotient, remainder, done). The top level holds the FSM, handshake and saturation/rounding.

Test Plan:
- rpm=5, start pulse -> valid exactly 12 cycles later; output 400, nasycenie=0; busy high in the intervening cycles.
- Sweep rpm=5,10,...,95 -> 400,200,133,100,80,66,57,50,44,40,36,33,30,28,26,25,23,22,21 (legacy table parity); with ROUND_NEAREST_EN, rpm=30 -> 67 and rpm=15 -> 133.
- rpm=1 -> 511, nasycenie=1; rpm=0 -> 511, nasycenie=1; rpm=4 -> 500, nasycenie=0; rpm=127 -> 15 (16 with ROUND_NEAREST_EN).
- rpm=20 accepted, then start with rpm=50 at cycle 3 and on the valid cycle -> both ignored; single valid, output 100; next start in IDLE -> 40.
- Assert rst at cycle 5 of DIV -> immediately busy=0, output 511, no valid; a new start after reset release gives the correct result.
- Back-to-back starts every IDLE cycle with random rpm -> every valid matches the floor/round model; valid never high for 2 consecutive cycles.

Source files
------------

// File: rtl/obliczanie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obliczanie_pkg
// Description : Shared definitions for the rpm -> ticks-per-degree calculator:
//               FSM state encoding, default tick constant, a constant-safe
//               clog2 helper and an all-ones generator used for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
package obliczanie_pkg;

    // Tick-clock cycles per degree at 1 rpm for a 12 kHz tick (12000*60/360).
    localparam int C_K_TAKT_DEFAULT = 2000;

    // Controller state encoding (kept as plain constants for legacy tools).
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DIV  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int f_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // All-ones pattern of the given width, right-aligned in 32 bits.
    function automatic logic [31:0] f_all_ones(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : obliczanie_pkg
`default_nettype wire

// File: rtl/dzielnik_sekwencyjny.sv
`default_nettype none
// ============================================================================
// Module      : dzielnik_sekwencyjny
// Description : Generic restoring divider, one quotient bit per clock, MSB
//               first. N_W iterations follow a load; done pulses for one
//               cycle once the last bit has been registered.
// Ports       : clk, rst (async, active-high), load, dividend[N_W], divisor[D_W]
//               -> quotient[N_W], remainder[D_W+1], done
// Revision    : 1.0 - initial release
// ============================================================================
module dzielnik_sekwencyjny
    import obliczanie_pkg::*;
#(
    parameter int N_W = 11,
    parameter int D_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N_W-1:0]   dividend,
    input  logic [D_W-1:0]   divisor,
    output logic [N_W-1:0]   quotient,
    output logic [D_W:0]     remainder,
    output logic             done
);

    localparam int C_CNT_W = f_clog2(N_W + 1);

    logic [N_W-1:0]     dvd_q, dvd_d;
    logic [D_W-1:0]     dsr_q, dsr_d;
    logic [D_W:0]       rem_q, rem_d;
    logic [N_W-1:0]     quot_q, quot_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [D_W:0]       w_rem_shift;
    logic               w_ge;

    // The partial remainder is always below the divisor (< 2^D_W) before the
    // shift, so D_W+1 bits hold the shifted value without overflow. A zero
    // divisor makes the compare always true; the caller handles that case.
    assign w_rem_shift = {rem_q[D_W-1:0], dvd_q[N_W-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, dsr_q});

    always_comb begin
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (load) begin
            dvd_d  = dividend;
            dsr_d  = divisor;
            rem_d  = '0;
            quot_d = '0;
            cnt_d  = C_CNT_W'(N_W);
        end else if (cnt_q != '0) begin
            dvd_d  = {dvd_q[N_W-2:0], 1'b0};
            rem_d  = w_ge ? (w_rem_shift - {1'b0, dsr_q}) : w_rem_shift;
            quot_d = {quot_q[N_W-2:0], w_ge};
            cnt_d  = cnt_q - C_CNT_W'(1);
            done_d = (cnt_q == C_CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule : dzielnik_sekwencyjny
`default_nettype wire

// File: rtl/obliczanie_taktowania_param.sv
`default_nettype none
// ============================================================================
// Module      : obliczanie_taktowania_param
// Description : Computes taktowanie_na_stopien = K_TAKT / rpm with a
//               sequential restoring divider and a start/valid handshake.
//               Results that do not fit OUT_W bits, or rpm == 0, saturate to
//               all-ones with nasycenie set. Fixed latency: valid rises Q_W+1
//               clocks after the accepting edge.
//               Build option: ROUND_NEAREST_EN - round to nearest instead of
//               floor (quotient+1 when 2*remainder >= rpm, before saturation).
// Ports       : clk, rst (async, active-high), start, rpm[RPM_W]
//               -> busy, valid, taktowanie_na_stopien[OUT_W], nasycenie
// Revision    : 1.0 - initial release
// ============================================================================
module obliczanie_taktowania_param
    import obliczanie_pkg::*;
#(
    parameter int RPM_W  = 7,
    parameter int OUT_W  = 9,
    parameter int K_TAKT = C_K_TAKT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RPM_W-1:0] rpm,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] taktowanie_na_stopien,
    output logic             nasycenie
);

    localparam int               Q_W        = f_clog2(K_TAKT + 1);
    localparam logic [Q_W-1:0]   C_DIVIDEND = Q_W'(K_TAKT);
    localparam logic [31:0]      C_ONES32   = f_all_ones(OUT_W);
    localparam logic [OUT_W-1:0] C_SAT      = C_ONES32[OUT_W-1:0];

    state_t             state_q, state_d;
    logic [RPM_W-1:0]   rpm_q, rpm_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   wynik_q, wynik_d;
    logic               nas_q, nas_d;

    logic               w_accept;
    logic [Q_W-1:0]     w_div_quot;
    logic [RPM_W:0]     w_div_rem;
    logic               w_div_done;
    logic [Q_W:0]       w_q_ext;
    logic [31:0]        w_q32;
    logic               w_sat;

    assign w_accept = (state_q == ST_IDLE) && start;

    dzielnik_sekwencyjny #(
        .N_W (Q_W),
        .D_W (RPM_W)
    ) u_dzielnik (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .dividend  (C_DIVIDEND),
        .divisor   (rpm),
        .quotient  (w_div_quot),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    // One extra bit so the rounding increment cannot wrap.
`ifdef ROUND_NEAREST_EN
    logic [RPM_W+1:0] w_rem2;
    logic             w_round_up;
    assign w_rem2     = {w_div_rem, 1'b0};
    assign w_round_up = (w_rem2 >= {2'b00, rpm_q});
    assign w_q_ext    = {1'b0, w_div_quot} + {{Q_W{1'b0}}, w_round_up};
`else
    assign w_q_ext    = {1'b0, w_div_quot};
`endif

    assign w_q32 = 32'(w_q_ext);
    assign w_sat = (rpm_q == '0) || (w_q32 > C_ONES32);

    // The result is registered on the edge that enters DONE, so valid and the
    // new output are both visible for the single cycle spent in DONE; a start
    // in that cycle is therefore ignored.
    always_comb begin
        state_d = state_q;
        rpm_d   = rpm_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        wynik_d = wynik_q;
        nas_d   = nas_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DIV;
                    rpm_d   = rpm;
                    busy_d  = 1'b1;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    wynik_d = w_sat ? C_SAT : w_q32[OUT_W-1:0];
                    nas_d   = w_sat;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rpm_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            wynik_q <= C_SAT;
            nas_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rpm_q   <= rpm_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            wynik_q <= wynik_d;
            nas_q   <= nas_d;
        end
    end

    assign busy                  = busy_q;
    assign valid                 = valid_q;
    assign taktowanie_na_stopien = wynik_q;
    assign nasycenie             = nas_q;

endmodule : obliczanie_taktowania_param
`default_nettype wire

// File: tb/tb_obliczanie_taktowania_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_obliczanie_taktowania_param
// Description : Self-checking bench for obliczanie_taktowania_param with the
//               default parameters (RPM_W=7, OUT_W=9, K_TAKT=2000). Expected
//               results come from plain integer division of K_TAKT by rpm.
//               Build option: ROUND_NEAREST_EN selects the rounding model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obliczanie_taktowania_param;

    localparam int K       = 2000;
    localparam int MAXOUT  = 511;
    localparam int LAT     = 12;
    localparam int PERIOD  = 14;   // accept-to-accept with start held high

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] rpm;
    logic       busy;
    logic       valid;
    logic [8:0] taktowanie_na_stopien;
    logic       nasycenie;

    int errors;
    int checks;

    obliczanie_taktowania_param #(
        .RPM_W  (7),
        .OUT_W  (9),
        .K_TAKT (K)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .rpm                   (rpm),
        .busy                  (busy),
        .valid                 (valid),
        .taktowanie_na_stopien (taktowanie_na_stopien),
        .nasycenie             (nasycenie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int r, output int val, output bit sat);
        int q;
        int rm;
        if (r == 0) begin
            val = MAXOUT;
            sat = 1'b1;
            return;
        end
        q  = K / r;
        rm = K % r;
`ifdef ROUND_NEAREST_EN
        if (2 * rm >= r) q = q + 1;
`endif
        if (q > MAXOUT) begin
            val = MAXOUT;
            sat = 1'b1;
        end else begin
            val = q;
            sat = 1'b0;
        end
    endfunction

    // Caller is #1 after an edge with the DUT idle. Returns latency in clocks
    // from the accepting edge (-1 if no valid within the budget).
    task automatic run_one(input int r, output int lat, output int out,
                           output bit nas, output bit busy_ok);
        start = 1'b1;
        rpm   = 7'(r);
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = -1;
        out     = 0;
        nas     = 1'b0;
        busy_ok = busy;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = c;
                out = int'(taktowanie_na_stopien);
                nas = nasycenie;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic check_result(input string name, input int r, input int lat,
                                input int out, input bit nas);
        int ev;
        bit es;
        model(r, ev, es);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s rpm=%0d latency: got %0d expected %0d", name, r, lat, LAT);
        end
        checks++;
        if (out !== ev || nas !== es) begin
            errors++;
            $display("FAIL %s rpm=%0d result: got %0d/nas=%0d expected %0d/nas=%0d",
                     name, r, out, nas, ev, es);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        rpm   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || nasycenie !== 1'b0 ||
            taktowanie_na_stopien !== 9'd511) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b nas=%b out=%0d expected 0 0 0 511",
                     busy, valid, nasycenie, taktowanie_na_stopien);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, out;
        bit nas, bok;
        run_one(5, lat, out, nas, bok);
        check_result("basic", 5, lat, out, nas);
        checks++;
        if (out !== 400 || nas !== 1'b0) begin
            errors++;
            $display("FAIL basic_const: got %0d/nas=%0d expected 400/nas=0", out, nas);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL basic_busy: busy=0 seen before valid (expected 1), or 1 with valid");
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_pulse: valid=%b on cycle after pulse, expected 0", valid);
        end
    endtask

    task automatic test_sweep();
        int lat, out;
        bit nas, bok;
`ifndef ROUND_NEAREST_EN
        int legacy[19] = '{400,200,133,100,80,66,57,50,44,40,36,33,30,28,26,25,23,22,21};
`endif
        for (int i = 0; i < 19; i++) begin
            run_one(5 * (i + 1), lat, out, nas, bok);
            check_result("sweep", 5 * (i + 1), lat, out, nas);
`ifndef ROUND_NEAREST_EN
            checks++;
            if (out !== legacy[i]) begin
                errors++;
                $display("FAIL sweep_legacy rpm=%0d: got %0d expected %0d",
                         5 * (i + 1), out, legacy[i]);
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundaries();
        int lat, out;
        bit nas, bok;
        int rv[6]  = '{1, 0, 4, 127, 30, 15};
`ifdef ROUND_NEAREST_EN
        int ex[6]  = '{511, 511, 500, 16, 67, 133};
`else
        int ex[6]  = '{511, 511, 500, 15, 66, 133};
`endif
        bit es[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_one(rv[i], lat, out, nas, bok);
            check_result("boundary", rv[i], lat, out, nas);
            checks++;
            if (out !== ex[i] || nas !== es[i]) begin
                errors++;
                $display("FAIL boundary_const rpm=%0d: got %0d/nas=%0d expected %0d/nas=%0d",
                         rv[i], out, nas, ex[i], es[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_start();
        int nvalid;
        int vcyc;
        int lat, out;
        bit nas, bok;
        start = 1'b1;
        rpm   = 7'd20;
        @(posedge clk); #1;
        start  = 1'b0;
        nvalid = 0;
        vcyc   = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) begin
                nvalid++;
                if (vcyc < 0) begin
                    vcyc = c;
                    checks++;
                    if (taktowanie_na_stopien !== 9'd100) begin
                        errors++;
                        $display("FAIL ignored_out: got %0d expected 100", taktowanie_na_stopien);
                    end
                    start = 1'b1;      // lands while the FSM is in DONE
                    rpm   = 7'd50;
                end
            end
            if (c == 3) begin
                start = 1'b1;
                rpm   = 7'd50;
            end
        end
        start = 1'b0;
        checks++;
        if (nvalid !== 1 || vcyc !== LAT) begin
            errors++;
            $display("FAIL ignored_single_valid: got %0d valids at cycle %0d expected 1 at %0d",
                     nvalid, vcyc, LAT);
        end
        run_one(50, lat, out, nas, bok);
        check_result("after_ignored", 50, lat, out, nas);
        checks++;
        if (out !== 40) begin
            errors++;
            $display("FAIL after_ignored_const: got %0d expected 40", out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int nvalid;
        int lat, out;
        bit nas, bok;
        start = 1'b1;
        rpm   = 7'd1;      // leaves nasycenie clear until DONE
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || taktowanie_na_stopien !== 9'd511 ||
            nasycenie !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b valid=%b out=%0d nas=%b expected 0 0 511 0",
                     busy, valid, taktowanie_na_stopien, nasycenie);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++;
            $display("FAIL reset_no_valid: got %0d valids expected 0", nvalid);
        end
        run_one(20, lat, out, nas, bok);
        check_result("after_reset", 20, lat, out, nas);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int hist[0:511];
        int e;
        int last_v;
        int nvalid;
        bit prev_v;
        int ev;
        bit es;
        e      = 0;
        last_v = -1;
        nvalid = 0;
        prev_v = 1'b0;
        start  = 1'b1;
        for (int cyc = 0; cyc < 20 * PERIOD; cyc++) begin
            rpm = 7'($urandom_range(0, 127));
            hist[e + 1] = int'(rpm);
            @(posedge clk); #1;
            e++;
            if (valid) begin
                nvalid++;
                model(hist[e - LAT], ev, es);
                checks++;
                if (int'(taktowanie_na_stopien) !== ev || nasycenie !== es) begin
                    errors++;
                    $display("FAIL b2b_result edge=%0d rpm=%0d: got %0d/nas=%0d expected %0d/nas=%0d",
                             e, hist[e - LAT], taktowanie_na_stopien, nasycenie, ev, es);
                end
                checks++;
                if ((last_v < 0 && e !== 1 + LAT) || (last_v >= 0 && e - last_v !== PERIOD)) begin
                    errors++;
                    $display("FAIL b2b_spacing: valid at edge %0d, previous %0d", e, last_v);
                end
                last_v = e;
            end
            if (valid && prev_v) begin
                errors++;
                $display("FAIL b2b_double_valid at edge %0d: valid=1 twice, expected single pulse", e);
            end
            prev_v = valid;
        end
        start = 1'b0;
        checks++;
        if (nvalid < 19) begin
            errors++;
            $display("FAIL b2b_count: got %0d valids expected at least 19", nvalid);
        end
        repeat (PERIOD + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_boundaries();
        test_ignored_start();
        test_reset_mid_div();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_obliczanie_taktowania_param
`default_nettype wire
